border_pad: RTL and testbench

- Sits between the demosaic stage and the sharpening filter in the processing pipeline.
- Takes the demosaiced RGB raster stream (width x height pixels, with row blanking).
- Emits a zero-bordered stream of (width+2*boundaryWidth) x (height+2*boundaryWidth) pixels in raster order, packed as {R,G,B}, which the KxK filter window consumes directly.
- Contains a pixel FIFO that absorbs the rate mismatch between input and padded output.

---
 rtl/isp_pkg.sv | 26 ++
 rtl/pixel_fifo.sv | 67 ++++++
 rtl/border_pad.sv | 190 +++++++++++++++++++
 tb/tb_border_pad.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/isp_pkg.sv
// Shared pixel-pipeline types: RGB pixel struct, border-pad FSM states and
// the kernel-to-border-width helper.
`timescale 1ns/1ps
package isp_pkg;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_TOP,
        S_LEFT,
        S_BODY,
        S_RIGHT,
        S_BOTTOM,
        S_DONE
    } pad_state_e;

    function automatic int boundary_w(input int kernel_size);
        return (kernel_size - 1) / 2;
    endfunction

endpackage

// File: rtl/pixel_fifo.sv
// Single-clock pixel FIFO with show-ahead head data (peek), full/empty flags,
// occupancy count and a flush that may coincide with a push.
`timescale 1ns/1ps
module pixel_fifo
    import isp_pkg::*;
#(
    parameter  int DEPTH = 2048,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_flush,
    input  logic        i_push,
    input  rgb_t        i_data,
    input  logic        i_pop,
    output rgb_t        o_data,
    output logic        o_full,
    output logic        o_empty,
    output logic [AW:0] o_count
);

    rgb_t          r_mem [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [AW:0]   r_cnt;

    logic          w_do_pop;
    logic          w_do_push;
    logic          w_wr_en;
    logic [AW-1:0] w_wr_idx;

    assign o_full   = (r_cnt == (AW+1)'(DEPTH));
    assign o_empty  = (r_cnt == '0);
    assign o_count  = r_cnt;
    assign o_data   = r_mem[r_rd];

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a push.
    assign w_do_pop  = i_pop && !o_empty && !i_flush;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign w_wr_en   = i_flush ? i_push : w_do_push;
    assign w_wr_idx  = i_flush ? '0 : r_wr;

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else if (i_flush) begin
            r_rd  <= '0;
            r_wr  <= i_push ? AW'(1) : '0;
            r_cnt <= i_push ? (AW+1)'(1) : '0;
        end else begin
            if (w_do_push) r_wr <= r_wr + 1'b1;
            if (w_do_pop)  r_rd <= r_rd + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_wr_en) r_mem[w_wr_idx] <= i_data;
    end

endmodule

// File: rtl/border_pad.sv
// Pads a demosaiced RGB frame with a (kernelSize-1)/2 border for the KxK filter.
// Define BORDER_PAD_REPLICATE_EN to replicate edge pixels into left/right borders.
`timescale 1ns/1ps
module border_pad
    import isp_pkg::*;
#(
    parameter int width      = 320,
    parameter int height     = 240,
    parameter int kernelSize = 7,
    parameter int fifoDepth  = 2048
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        newFrame,
    input  logic        iValid,
    input  logic [7:0]  iR,
    input  logic [7:0]  iG,
    input  logic [7:0]  iB,
    output logic        oValid,
    output logic [23:0] oData,
    output logic        oDone,
    output logic        oOverflow
);

    localparam int BW       = boundary_w(kernelSize);
    localparam int ROW_SIZE = width + 2*BW;
    localparam int PAD_ROWS = height + 2*BW;
    localparam int NPIX     = width * height;
    localparam int CW       = $clog2(ROW_SIZE);
    localparam int RW       = $clog2(PAD_ROWS);
    localparam int IW       = $clog2(NPIX + 1);
    localparam int FAW      = $clog2(fifoDepth);

    localparam logic [CW-1:0] COL_LEFT_LAST = CW'(BW - 1);
    localparam logic [CW-1:0] COL_BODY_LAST = CW'(BW + width - 1);
    localparam logic [CW-1:0] COL_LAST      = CW'(ROW_SIZE - 1);
    localparam logic [RW-1:0] ROW_TOP_LAST  = RW'(BW - 1);
    localparam logic [RW-1:0] ROW_BODY_LAST = RW'(BW + height - 1);
    localparam logic [RW-1:0] ROW_LAST      = RW'(PAD_ROWS - 1);

    pad_state_e    r_state;
    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;
    logic [IW-1:0] r_in_cnt;

    pad_state_e    w_st;
    pad_state_e    w_nxt;
    logic [CW-1:0] w_col;
    logic [CW-1:0] w_col_nxt;
    logic [CW-1:0] w_col_inc;
    logic [RW-1:0] w_row;
    logic [RW-1:0] w_row_nxt;
    logic          w_row_end;
    logic [IW-1:0] w_in_cnt;
    logic          w_emit;
    rgb_t          w_pix;
    logic          w_pop;
    logic          w_accept;
    logic          w_ovf;
    rgb_t          w_in_pix;
    rgb_t          w_head;
    logic          w_full;
    logic          w_empty;
    logic [FAW:0]  w_count_unused;

`ifdef BORDER_PAD_REPLICATE_EN
    rgb_t          r_last;
`endif

    assign w_in_pix = '{r: iR, g: iG, b: iB};

    pixel_fifo #(.DEPTH(fifoDepth)) u_fifo (
        .i_clk   (clk),
        .i_reset (reset),
        .i_flush (newFrame),
        .i_push  (w_accept),
        .i_data  (w_in_pix),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count_unused)
    );

    // newFrame restarts at the first TOP pixel in the same cycle, giving 1-cycle latency.
    assign w_st     = newFrame ? S_TOP : r_state;
    assign w_col    = newFrame ? '0 : r_col;
    assign w_row    = newFrame ? '0 : r_row;
    assign w_in_cnt = newFrame ? '0 : r_in_cnt;

    assign w_accept = iValid && (w_st != S_IDLE) && (w_st != S_DONE) && (w_in_cnt < IW'(NPIX));
    assign w_ovf    = w_accept && w_full && !w_pop && !newFrame;

    always_comb begin
        w_nxt     = w_st;
        w_col_nxt = w_col;
        w_row_nxt = w_row;
        w_emit    = 1'b0;
        w_pix     = '0;
        w_pop     = 1'b0;
        w_row_end = (w_col == COL_LAST);
        w_col_inc = w_row_end ? '0 : w_col + 1'b1;
        case (w_st)
            S_TOP: begin
                w_emit    = 1'b1;
                w_col_nxt = w_col_inc;
                if (w_row_end) begin
                    w_row_nxt = w_row + 1'b1;
                    if (w_row == ROW_TOP_LAST) w_nxt = S_LEFT;
                end
            end
            S_LEFT: begin
`ifdef BORDER_PAD_REPLICATE_EN
                w_emit = !w_empty;
                w_pix  = w_head;
`else
                w_emit = 1'b1;
`endif
                if (w_emit) begin
                    w_col_nxt = w_col + 1'b1;
                    if (w_col == COL_LEFT_LAST) w_nxt = S_BODY;
                end
            end
            S_BODY: begin
                if (!w_empty) begin
                    w_emit    = 1'b1;
                    w_pop     = 1'b1;
                    w_pix     = w_head;
                    w_col_nxt = w_col + 1'b1;
                    if (w_col == COL_BODY_LAST) w_nxt = S_RIGHT;
                end
            end
            S_RIGHT: begin
                w_emit    = 1'b1;
`ifdef BORDER_PAD_REPLICATE_EN
                w_pix     = r_last;
`endif
                w_col_nxt = w_col_inc;
                if (w_row_end) begin
                    w_row_nxt = w_row + 1'b1;
                    w_nxt     = (w_row == ROW_BODY_LAST) ? S_BOTTOM : S_LEFT;
                end
            end
            S_BOTTOM: begin
                w_emit    = 1'b1;
                w_col_nxt = w_col_inc;
                if (w_row_end) begin
                    if (w_row == ROW_LAST) begin
                        w_row_nxt = '0;
                        w_nxt     = S_DONE;
                    end else begin
                        w_row_nxt = w_row + 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_col     <= '0;
            r_row     <= '0;
            r_in_cnt  <= '0;
            oValid    <= 1'b0;
            oData     <= '0;
            oDone     <= 1'b0;
            oOverflow <= 1'b0;
        end else begin
            r_state  <= w_nxt;
            r_col    <= w_col_nxt;
            r_row    <= w_row_nxt;
            r_in_cnt <= w_in_cnt + IW'(w_accept);
            oValid   <= w_emit;
            oData    <= w_emit ? w_pix : '0;
            oDone    <= (w_st == S_DONE);
            if (w_ovf) oOverflow <= 1'b1;
        end
    end

`ifdef BORDER_PAD_REPLICATE_EN
    // Right border repeats the last body pixel of the current row.
    always_ff @(posedge clk) begin
        if (!reset)     r_last <= '0;
        else if (w_pop) r_last <= w_head;
    end
`endif

endmodule

// File: tb/tb_border_pad.sv
// Directed bench for border_pad: small-geometry frames, stall, abort, reset and overflow.
`timescale 1ns/1ps
module tb_border_pad;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        newFrame = 1'b0;
    logic        iValid = 1'b0;
    logic [7:0]  iR = '0, iG = '0, iB = '0;
    logic        oValid;
    logic [23:0] oData;
    logic        oDone, oOverflow;

    logic        nf2 = 1'b0, iv2 = 1'b0;
    logic [7:0]  px2 = '0;
    logic        oValid2;
    logic [23:0] oData2;
    logic        oDone2, oOverflow2;

    int errors = 0;
    int checks = 0;

    logic [23:0] got  [32];
    logic [23:0] expv [24];
    int n_got, first_v, last_v, first_d;

    always #5 clk = ~clk;

    border_pad #(.width(4), .height(2), .kernelSize(3), .fifoDepth(16)) dut (
        .clk(clk), .reset(reset), .newFrame(newFrame), .iValid(iValid),
        .iR(iR), .iG(iG), .iB(iB),
        .oValid(oValid), .oData(oData), .oDone(oDone), .oOverflow(oOverflow)
    );

    border_pad #(.width(8), .height(2), .kernelSize(3), .fifoDepth(4)) dut_ovf (
        .clk(clk), .reset(reset), .newFrame(nf2), .iValid(iv2),
        .iR(px2), .iG(px2), .iB(px2),
        .oValid(oValid2), .oData(oData2), .oDone(oDone2), .oOverflow(oOverflow2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // newFrame at cycle 0; pixel k (value k on R=G=B) at first_cyc+k-1, delayed by gap_len after pixel gap_after.
    task automatic run_frame(input int first_cyc, input int gap_after, input int gap_len, input int ncyc);
        n_got = 0; first_v = -1; last_v = -1; first_d = -1;
        for (int c = 0; c < ncyc; c++) begin
            newFrame = (c == 0);
            iValid   = 1'b0;
            for (int k = 1; k <= 8; k++) begin
                if (first_cyc + k - 1 + ((k > gap_after) ? gap_len : 0) == c) begin
                    iValid = 1'b1;
                    iR = 8'(k); iG = 8'(k); iB = 8'(k);
                end
            end
            step();
            if (oValid) begin
                if (n_got < 32) got[n_got] = oData;
                n_got++;
                if (first_v < 0) first_v = c;
                last_v = c;
            end
            if (oDone && first_d < 0) first_d = c;
        end
        newFrame = 1'b0;
        iValid   = 1'b0;
    endtask

    task automatic check_frame(input string tag, input int exp_gap);
        chk({tag, "_count"}, n_got, 24);
        for (int i = 0; i < 24; i++) chk($sformatf("%s_pix%0d", tag, i), got[i], expv[i]);
        chk({tag, "_first"}, first_v, 0);
        chk({tag, "_gap"}, last_v - first_v + 1 - n_got, exp_gap);
        chk({tag, "_done"}, first_d, last_v + 1);
    endtask

    initial begin
        for (int i = 0; i < 24; i++) expv[i] = '0;
        for (int r = 1; r <= 2; r++) begin
            for (int c = 1; c <= 4; c++) expv[r*6 + c] = 24'(32'h010101 * ((r-1)*4 + c));
`ifdef BORDER_PAD_REPLICATE_EN
            expv[r*6]     = expv[r*6 + 1];
            expv[r*6 + 5] = expv[r*6 + 4];
`endif
        end

        // Reset state
        repeat (3) step();
        chk("rst_valid", oValid, 0);
        chk("rst_data", oData, 0);
        chk("rst_done", oDone, 0);
        chk("rst_ovf", oOverflow, 0);
        chk("rst_ovf2", oOverflow2, 0);
        chk("rst_valid2", oValid2, 0);
        reset = 1'b1;
        repeat (3) step();
        chk("idle_valid", oValid, 0);

        // Basic frame: 24 outputs, no stalls, oDone right after last pixel
        run_frame(1, 8, 0, 40);
        check_frame("basic", 0);
        chk("done_hold", oDone, 1);

        // Input withheld 20 cycles after pixel 2: 15 output stall cycles, order kept
        run_frame(1, 2, 20, 60);
        check_frame("stall", 15);

        // Abort mid-frame, then newFrame together with pixel 0 of the new frame
        run_frame(1, 8, 0, 12);
        run_frame(0, 8, 0, 40);
        check_frame("abort", 0);

        // Reset mid-BODY, then a fresh frame
        run_frame(1, 8, 0, 10);
        reset = 1'b0;
        step();
        chk("midrst_valid", oValid, 0);
        chk("midrst_data", oData, 0);
        chk("midrst_done", oDone, 0);
        chk("midrst_ovf", oOverflow, 0);
        reset = 1'b1;
        n_got = 0;
        for (int c = 0; c < 5; c++) begin
            step();
            if (oValid) n_got++;
        end
        chk("postrst_idle", n_got, 0);
        run_frame(1, 8, 0, 40);
        check_frame("rerun", 0);
        chk("rerun_ovf", oOverflow, 0);

        // Overflow: depth-4 FIFO, 8 back-to-back pushes during TOP
        for (int c = 0; c <= 8; c++) begin
            nf2 = (c == 0);
            iv2 = (c >= 1);
            px2 = 8'(c);
            step();
            if (c == 4) chk("ovf_after4", oOverflow2, 0);
            if (c == 5) chk("ovf_after5", oOverflow2, 1);
        end
        nf2 = 1'b0;
        iv2 = 1'b0;
        repeat (20) step();
        chk("ovf_sticky", oOverflow2, 1);
        reset = 1'b0;
        step();
        chk("ovf_reset", oOverflow2, 0);
        reset = 1'b1;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
